// File: rtl/decode_stage_if.sv
// decode_stage_if: bundles the decode stage's fetch-side, writeback and ALU-side signals.
// Ports (the slave modport is the stage's view; the master modport is the surrounding pipeline's view):
//   fetch side : in_valid, in_ready, instr, flush
//   writeback  : wb_en, wb_addr, wb_data
//   ALU side   : out_valid, out_ready, rs1, rs2, funct3, funct7, rd_addr, illegal
interface decode_stage_if #(parameter int XLEN = 32);
   logic            in_valid, in_ready, flush, wb_en, out_valid, out_ready, funct7, illegal;
   logic [31:0]     instr;
   logic [4:0]      wb_addr, rd_addr;
   logic [2:0]      funct3;
   logic [XLEN-1:0] wb_data, rs1, rs2;
   modport master (
      output in_valid, instr, flush, wb_en, wb_addr, wb_data, out_ready,
      input  in_ready, out_valid, rs1, rs2, funct3, funct7, rd_addr, illegal
   );
   modport slave (
      input  in_valid, instr, flush, wb_en, wb_addr, wb_data, out_ready,
      output in_ready, out_valid, rs1, rs2, funct3, funct7, rd_addr, illegal
   );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I R-type / I-type ALU decode and operand fetch with a 32x32 register file.
// Ports: clk, rst (sync, active high), bus (decode_stage_if.slave: fetch handshake, writeback port,
//        registered ALU output slot). XLEN must be at least 12.
// Option: define DECODE_BYPASS_EN to forward same-cycle writeback data into the captured operands.
module decode_stage #(
   parameter int XLEN = 32
) (
   input logic           clk,
   input logic           rst,
   decode_stage_if.slave bus
);
   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;
   logic [XLEN-1:0] regs_q [32];
   logic [XLEN-1:0] regs_d [32];
   logic            out_valid_q, out_valid_d, illegal_q, illegal_d, funct7_q, funct7_d;
   logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [4:0]      rd_addr_q, rd_addr_d;
   logic            wr_en, accept, is_r, is_i, fwd1, fwd2;
   logic [4:0]      src1, src2;
   logic [XLEN-1:0] opa, opb, imm;
   assign src1     = bus.instr[19:15];
   assign src2     = bus.instr[24:20];
   assign is_r     = bus.instr[6:0] == OP_R;
   assign is_i     = bus.instr[6:0] == OP_I;
   assign imm      = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
   assign wr_en    = bus.wb_en && bus.wb_addr != 5'd0;
   assign bus.in_ready = !bus.flush && (!out_valid_q || bus.out_ready);
   assign accept   = bus.in_valid && bus.in_ready;
`ifdef DECODE_BYPASS_EN
   assign fwd1 = wr_en && bus.wb_addr == src1;
   assign fwd2 = wr_en && bus.wb_addr == src2;
`else
   assign fwd1 = 1'b0;
   assign fwd2 = 1'b0;
`endif
   // x0 is forced to zero on the read side as well, so it never depends on regs_q[0]
   assign opa = src1 == 5'd0 ? '0 : fwd1 ? bus.wb_data : regs_q[src1];
   assign opb = src2 == 5'd0 ? '0 : fwd2 ? bus.wb_data : regs_q[src2];
   always_comb begin
      regs_d = regs_q;
      if (wr_en) regs_d[bus.wb_addr] = bus.wb_data;
      // accept is already blocked by flush through in_ready
      out_valid_d = bus.flush ? 1'b0 : accept ? 1'b1 : bus.out_ready ? 1'b0 : out_valid_q;
      illegal_d   = accept ? !(is_r || is_i) : illegal_q;
      funct3_d    = accept ? bus.instr[14:12] : funct3_q;
      rs1_d       = accept ? ((is_r || is_i) ? opa : '0) : rs1_q;
      rs2_d       = accept ? (is_r ? opb : is_i ? imm : '0) : rs2_q;
      // I-type only carries the alternate bit for SRAI; there is no SUBI
      funct7_d    = accept ? (is_r ? bus.instr[30] : is_i && bus.instr[14:12] == 3'b101 && bus.instr[30]) : funct7_q;
      rd_addr_d   = accept ? ((is_r || is_i) ? bus.instr[11:7] : 5'd0) : rd_addr_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
         out_valid_q <= 1'b0;
         illegal_q   <= 1'b0;
         funct7_q    <= 1'b0;
         funct3_q    <= 3'd0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_addr_q   <= 5'd0;
      end else begin
         regs_q      <= regs_d;
         out_valid_q <= out_valid_d;
         illegal_q   <= illegal_d;
         funct7_q    <= funct7_d;
         funct3_q    <= funct3_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rd_addr_q   <= rd_addr_d;
      end
   end
   assign bus.out_valid = out_valid_q;
   assign bus.illegal   = illegal_q;
   assign bus.funct7    = funct7_q;
   assign bus.funct3    = funct3_q;
   assign bus.rs1       = rs1_q;
   assign bus.rs2       = rs2_q;
   assign bus.rd_addr   = rd_addr_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a behavioural model.
module tb_decode_stage;
   localparam int XLEN = 32;
`ifdef DECODE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   decode_stage_if #(.XLEN(XLEN)) bus ();
   decode_stage #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));
   int vectors = 0;
   int miscompares = 0;
   logic [31:0] m_rf [32];
   logic        m_valid, m_ill, m_f7, m_ir, ir_obs;
   logic [31:0] m_rs1, m_rs2;
   logic [2:0]  m_f3;
   logic [4:0]  m_rd;
   logic [74:0] slot, m_slot;
   assign slot   = {bus.out_valid, bus.illegal, bus.rs1, bus.rs2, bus.funct3, bus.funct7, bus.rd_addr};
   assign m_slot = {m_valid, m_ill, m_rs1, m_rs2, m_f3, m_f7, m_rd};

   function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] b, input logic [4:0] a,
                                         input logic [2:0] f3, input logic [4:0] d);
      return {f7, b, a, f3, d, 7'b0110011};
   endfunction

   function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] a, input logic [2:0] f3,
                                         input logic [4:0] d);
      return {imm, a, f3, d, 7'b0010011};
   endfunction

   function automatic logic [31:0] src(input logic [4:0] a, input logic we, input logic [4:0] wa,
                                       input logic [31:0] wd);
      return (a == 5'd0) ? 32'd0 : (BYP && we && wa == a) ? wd : m_rf[a];
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.instr = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
      bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      {m_valid, m_ill, m_rs1, m_rs2, m_f3, m_f7, m_rd} = '0;
      #1;
   endtask

   // Applies one cycle of inputs, advances the model by the same cycle, and returns #1 after the edge.
   task automatic drive(input logic v, input logic [31:0] ins, input logic fl, input logic ordy,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
      logic acc;
      bus.in_valid = v; bus.instr = ins; bus.flush = fl; bus.out_ready = ordy;
      bus.wb_en = we; bus.wb_addr = wa; bus.wb_data = wd;
      #1 ir_obs = bus.in_ready;
      m_ir = !fl && (!m_valid || ordy);
      acc  = v && m_ir;
      if (acc) begin
         m_f3  = ins[14:12];
         m_ill = 1'b0;
         if (ins[6:0] == 7'b0110011)
            {m_rs1, m_rs2, m_f7, m_rd} = {src(ins[19:15], we, wa, wd), src(ins[24:20], we, wa, wd), ins[30], ins[11:7]};
         else if (ins[6:0] == 7'b0010011)
            {m_rs1, m_rs2, m_f7, m_rd} = {src(ins[19:15], we, wa, wd), {{20{ins[31]}}, ins[31:20]},
                                          ins[14:12] == 3'b101 && ins[30], ins[11:7]};
         else begin
            {m_rs1, m_rs2, m_f7, m_rd} = '0;
            m_ill = 1'b1;
         end
      end
      m_valid = fl ? 1'b0 : acc ? 1'b1 : ordy ? 1'b0 : m_valid;
      if (we && wa != 5'd0) m_rf[wa] = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (slot !== 75'd0) begin miscompares++; $display("FAIL reset_slot got %h want %h", slot, 75'd0); end
      vectors++;
      if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
   endtask

   task automatic test_add();
      drive(0, '0, 0, 1, 1, 5'd5, 32'd20);
      drive(0, '0, 0, 1, 1, 5'd6, 32'd30);
      drive(1, r_ins(7'h00, 5'd6, 5'd5, 3'd0, 5'd7), 0, 1, 0, '0, '0);
      vectors++;
      if (ir_obs !== 1'b1) begin miscompares++; $display("FAIL add_in_ready got %b want 1", ir_obs); end
      vectors++;
      if (slot !== {1'b1, 1'b0, 32'd20, 32'd30, 3'd0, 1'b0, 5'd7}) begin
         miscompares++; $display("FAIL add_slot got %h want %h", slot, {1'b1, 1'b0, 32'd20, 32'd30, 3'd0, 1'b0, 5'd7});
      end
   endtask

   task automatic test_alt_ops();
      drive(1, r_ins(7'h20, 5'd6, 5'd5, 3'd0, 5'd7), 0, 1, 0, '0, '0);
      vectors++;
      if (slot !== {1'b1, 1'b0, 32'd20, 32'd30, 3'd0, 1'b1, 5'd7}) begin
         miscompares++; $display("FAIL sub_slot got %h want %h", slot, {1'b1, 1'b0, 32'd20, 32'd30, 3'd0, 1'b1, 5'd7});
      end
      drive(1, i_ins(12'h403, 5'd5, 3'd5, 5'd8), 0, 1, 0, '0, '0);
      vectors++;
      if ({bus.out_valid, bus.funct7, bus.rs2[4:0], bus.rs1, bus.funct3, bus.rd_addr} !== {1'b1, 1'b1, 5'd3, 32'd20, 3'd5, 5'd8}) begin
         miscompares++;
         $display("FAIL srai got valid=%b f7=%b shamt=%0d rs1=%0d f3=%0d rd=%0d want 1 1 3 20 5 8",
                  bus.out_valid, bus.funct7, bus.rs2[4:0], bus.rs1, bus.funct3, bus.rd_addr);
      end
      drive(1, i_ins(12'hFFF, 5'd0, 3'd0, 5'd9), 0, 1, 0, '0, '0);
      vectors++;
      if (slot !== {1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF, 3'd0, 1'b0, 5'd9}) begin
         miscompares++; $display("FAIL addi_slot got %h want %h", slot, {1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF, 3'd0, 1'b0, 5'd9});
      end
   endtask

   task automatic test_stall();
      logic [31:0] a = r_ins(7'h00, 5'd6, 5'd5, 3'd0, 5'd10);
      for (int k = 0; k < 3; k++) begin
         drive(1, a, 0, 0, 0, '0, '0);
         vectors++;
         if (ir_obs !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready[%0d] got %b want 0", k, ir_obs); end
         vectors++;
         if (slot !== {1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF, 3'd0, 1'b0, 5'd9}) begin
            miscompares++; $display("FAIL stall_hold[%0d] got %h want %h", k, slot, {1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF, 3'd0, 1'b0, 5'd9});
         end
      end
      drive(1, a, 0, 1, 0, '0, '0);
      vectors++;
      if ({ir_obs, slot} !== {1'b1, 1'b1, 1'b0, 32'd20, 32'd30, 3'd0, 1'b0, 5'd10}) begin
         miscompares++; $display("FAIL stall_release got ir=%b slot=%h want ir=1 slot=%h", ir_obs, slot,
                                 {1'b1, 1'b0, 32'd20, 32'd30, 3'd0, 1'b0, 5'd10});
      end
      drive(0, '0, 0, 1, 0, '0, '0);
      vectors++;
      if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_no_dup got %b want 0", bus.out_valid); end
   endtask

   task automatic test_bypass();
      logic [31:0] e1 = BYP ? 32'd99 : 32'd20;
      drive(1, r_ins(7'h00, 5'd0, 5'd5, 3'd0, 5'd1), 0, 1, 1, 5'd5, 32'd99);
      vectors++;
      if (slot !== {1'b1, 1'b0, e1, 32'd0, 3'd0, 1'b0, 5'd1}) begin
         miscompares++; $display("FAIL bypass_same_cycle got %h want %h", slot, {1'b1, 1'b0, e1, 32'd0, 3'd0, 1'b0, 5'd1});
      end
      drive(1, r_ins(7'h00, 5'd0, 5'd5, 3'd0, 5'd2), 0, 1, 0, '0, '0);
      vectors++;
      if (bus.rs1 !== 32'd99) begin miscompares++; $display("FAIL bypass_next_read got %0d want 99", bus.rs1); end
      drive(0, '0, 0, 1, 1, 5'd0, 32'd7);
      drive(1, r_ins(7'h00, 5'd0, 5'd0, 3'd0, 5'd3), 0, 1, 1, 5'd0, 32'd7);
      vectors++;
      if (slot !== {1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 5'd3}) begin
         miscompares++; $display("FAIL x0_read got %h want %h", slot, {1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 5'd3});
      end
   endtask

   task automatic test_flush();
      drive(1, r_ins(7'h00, 5'd6, 5'd5, 3'd0, 5'd3), 0, 1, 0, '0, '0);
      drive(1, r_ins(7'h00, 5'd6, 5'd5, 3'd0, 5'd4), 1, 0, 1, 5'd11, 32'd55);
      vectors++;
      if ({ir_obs, bus.out_valid} !== 2'b00) begin
         miscompares++; $display("FAIL flush got in_ready=%b out_valid=%b want 0 0", ir_obs, bus.out_valid);
      end
      drive(0, '0, 0, 1, 0, '0, '0);
      vectors++;
      if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_discard got %b want 0", bus.out_valid); end
      drive(1, r_ins(7'h00, 5'd0, 5'd11, 3'd0, 5'd12), 0, 1, 0, '0, '0);
      vectors++;
      if (slot !== {1'b1, 1'b0, 32'd55, 32'd0, 3'd0, 1'b0, 5'd12}) begin
         miscompares++; $display("FAIL flush_write got %h want %h", slot, {1'b1, 1'b0, 32'd55, 32'd0, 3'd0, 1'b0, 5'd12});
      end
   endtask

   task automatic test_illegal_reset();
      drive(1, 32'h0000_007F, 0, 1, 0, '0, '0);
      vectors++;
      if (slot !== {1'b1, 1'b1, 73'd0}) begin miscompares++; $display("FAIL illegal got %h want %h", slot, {1'b1, 1'b1, 73'd0}); end
      drive(0, '0, 0, 0, 0, '0, '0);
      vectors++;
      if (slot !== {1'b1, 1'b1, 73'd0}) begin miscompares++; $display("FAIL illegal_hold got %h want %h", slot, {1'b1, 1'b1, 73'd0}); end
      do_reset();
      vectors++;
      if ({bus.in_ready, slot} !== {1'b1, 75'd0}) begin
         miscompares++; $display("FAIL mid_stall_reset got ir=%b slot=%h want ir=1 slot=0", bus.in_ready, slot);
      end
      drive(1, r_ins(7'h00, 5'd6, 5'd5, 3'd0, 5'd7), 0, 1, 0, '0, '0);
      vectors++;
      if (slot !== {1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 5'd7}) begin
         miscompares++; $display("FAIL regfile_cleared got %h want %h", slot, {1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 5'd7});
      end
   endtask

   task automatic test_random();
      logic [31:0] w;
      int sel;
      for (int n = 0; n < 400; n++) begin
         w   = $urandom();
         sel = $urandom_range(0, 4);
         w[6:0]   = sel < 2 ? 7'b0110011 : sel < 4 ? 7'b0010011 : w[6:0];
         w[19:15] = 5'($urandom_range(0, 7));
         w[24:20] = 5'($urandom_range(0, 7));
         drive($urandom_range(0, 3) != 0, w, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
         vectors++;
         if (ir_obs !== m_ir) begin miscompares++; $display("FAIL rand_in_ready[%0d] got %b want %b", n, ir_obs, m_ir); end
         vectors++;
         if (bus.out_valid !== m_valid || (m_valid && slot !== m_slot)) begin
            miscompares++; $display("FAIL rand_slot[%0d] got %h want %h", n, slot, m_slot);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_alt_ops();
      test_stall();
      test_bypass();
      test_flush();
      test_illegal_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
